boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Drives the byte-memory boot/debug write port: `debug`, `boot_addr`, `boot_data`.
- Accepts a framed byte stream over a valid/ready handshake, typically from a UART receiver.
- Writes the payload bytes into data memory at consecutive addresses and holds the CPU stalled while loading.
- Reports completion or error (checksum mismatch, bad length, or timeout).

Parameters:
- ADDR_W, 13, byte-address width of target memory (8 KB)
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT, 50000, max idle cycles between bytes inside a frame before abort
- TMO_W, 16, timeout counter width (must hold TIMEOUT)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- debug  out  1  one-cycle write strobe to memory boot port
- boot_addr  out  ADDR_W  memory write address
- boot_data  out  8  memory write data
- cpu_hold  out  1  high while a frame is in progress (stall CPU)
- done  out  1  one-cycle pulse: frame loaded, checksum good
- err  out  1  one-cycle pulse: frame aborted
- err_code  out  2  cause of last err: 1 = checksum, 2 = length, 3 = timeout; holds until next err

Behaviour:
- Interface decisions:
  - One clock; reset is synchronous and active-high.
  - Ports named `clk` and `rst`.
- Reset values: rx_ready=0, debug=0, boot_addr=0, boot_data=0, cpu_hold=0, done=0, err=0, err_code=0, state=IDLE.
  - rx_ready rises the cycle after rst deasserts, then stays 1 in all states.
- Handshake: a byte is accepted on a posedge where rx_valid && rx_ready.
- Frame format, in order:
  - SYNC_BYTE
  - ADDR_L, ADDR_H: start address, little-endian; upper bits beyond ADDR_W ignored
  - LEN_L, LEN_H: byte count, 0..2^ADDR_W
  - LEN payload bytes
  - CSUM: 8-bit modulo-256 sum of the payload bytes
- FSM states: IDLE, ADDR_L, ADDR_H, LEN_L, LEN_H, DATA, CSUM.
- IDLE:
  - Accepted bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE -> ADDR_L, and cpu_hold rises the following cycle.
- ADDR_L -> ADDR_H -> LEN_L -> LEN_H.
  - At LEN_H accept: len > 2^ADDR_W -> err (code 2), go to IDLE.
  - len == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: each accepted byte produces, on the next cycle:
  - debug=1 for exactly one cycle
  - boot_data = byte
  - boot_addr = current write pointer
- Write pointer:
  - Starts at the start address and increments by 1 after each write.
  - Wraps modulo 2^ADDR_W (0x1FFF -> 0x0000).
- Write stability: boot_addr and boot_data are registered and hold their values after debug falls. The memory samples on negedge, so values are stable mid-cycle.
- Running sum: checksum accumulator is 8 bits, cleared on SYNC accept and updated on each payload accept. After the last payload byte -> CSUM.
- CSUM accept:
  - match -> done pulse
  - mismatch -> err pulse, code 1
  - Either way go to IDLE. Bytes already written are not rolled back.
- cpu_hold drops in the same cycle done/err pulses, and is never high in IDLE.
- Timeout:
  - In any non-IDLE state, the idle counter increments each cycle without an accept and clears on accept.
  - On reaching TIMEOUT: err pulse, code 3, go to IDLE.
- Back-to-back bytes: a byte every cycle is legal. Consecutive debug pulses are allowed with a different boot_addr each cycle.
- Reset mid-frame: all outputs go to reset values next cycle. No further debug strobes; the partial load remains in memory.
- done and err are never asserted together.

Decomposition:
- Shared package `boot_pkg`:
  - state enum typedef
  - SYNC_BYTE default
  - err_code localparams (ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TMO)
- Single module; no sub-module needed.
- Optional tiny sub-module `boot_timeout_cnt` (counter with clear/expire) if reused by the UART block.

Test Plan:
- Normal frame:
  - Stimulus: A5 00 01 04 00 11 22 33 44 AA, one byte per cycle.
  - Expect four debug pulses: addr 0x100..0x103 with data 11, 22, 33, 44.
  - Expect done pulse, cpu_hold high from SYNC+1 to done, err never.
- Checksum error:
  - Stimulus: same frame with CSUM=AB.
  - Expect four writes, then err=1 with err_code=1, and no done.
- Wrap and garbage:
  - Stimulus: leading garbage 00 FF 5A, then A5 FF 1F 02 00 01 02 03.
  - Expect garbage ignored.
  - Expect writes at 0x1FFF then 0x0000, then done.
- Length zero and length too long:
  - Length 0: A5 10 00 00 00 00 -> done with no debug pulse.
  - Length 0x2001: err, err_code=2.
- Timeout:
  - Stimulus: A5 00 00 then stall TIMEOUT cycles.
  - Expect err, err_code=3, and cpu_hold low after.
  - A new frame afterwards loads correctly.
- Reset mid-frame:
  - Stimulus: rst asserted after 2 payload bytes.
  - Expect all outputs at reset values next cycle and no further debug strobes.
  - A subsequent full frame gives done.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: frame-parser states, default sync
// marker and error-cause codes reported on err_code.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_L,
    ADDR_H,
    LEN_L,
    LEN_H,
    DATA,
    CSUM
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/boot_loader.sv
// Boot loader: parses a framed byte stream (SYNC, ADDR_L/H, LEN_L/H, payload,
// CSUM) from a valid/ready source and writes the payload into byte memory
// through the debug/boot write port, stalling the CPU while a frame is open.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  incoming byte and its valid
//   rx_ready          loader can take a byte (1 from the cycle after reset)
//   debug             one-cycle memory write strobe
//   boot_addr/data    registered write address/data, held between strobes
//   cpu_hold          high while a frame is in progress
//   done / err        one-cycle completion / abort pulses
//   err_code          cause of the most recent err (1 csum, 2 len, 3 timeout)
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned TMO_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              debug,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [7:0]        boot_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // Remaining-byte counter must hold the full 2^ADDR_W length.
  localparam int unsigned   LEN_W    = ADDR_W + 1;
  localparam logic [15:0]   LEN_MAX  = 16'(1 << ADDR_W);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               rx_ready_q;
  logic               debug_q, debug_d;
  logic [ADDR_W-1:0]  boot_addr_q, boot_addr_d;
  logic [7:0]         boot_data_q, boot_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [7:0]         addr_lo_q, addr_lo_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         sum_q, sum_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               accept;
  logic [15:0]        len_w;

  assign accept = rx_valid && rx_ready_q;
  assign len_w  = {rx_data, len_lo_q};

  // Frame parser, write-port drive and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    debug_d     = 1'b0;
    boot_addr_d = boot_addr_q;
    boot_data_d = boot_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    wptr_d      = wptr_q;
    addr_lo_d   = addr_lo_q;
    len_lo_d    = len_lo_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    tmo_d       = '0;

    if (state_q != IDLE) begin
      tmo_d = accept ? '0 : tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = ADDR_L;
          sum_d   = '0;
        end
      end
      ADDR_L: begin
        if (accept) begin
          addr_lo_d = rx_data;
          state_d   = ADDR_H;
        end
      end
      ADDR_H: begin
        if (accept) begin
          // Address bits above ADDR_W are dropped.
          wptr_d  = ADDR_W'({rx_data, addr_lo_q});
          state_d = LEN_L;
        end
      end
      LEN_L: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = LEN_H;
        end
      end
      LEN_H: begin
        if (accept) begin
          if (len_w > LEN_MAX) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = IDLE;
          end else if (len_w == 16'd0) begin
            state_d = CSUM;
          end else begin
            rem_d   = LEN_W'(len_w);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          debug_d     = 1'b1;
          boot_addr_d = wptr_q;
          boot_data_d = rx_data;
          wptr_d      = wptr_q + ADDR_W'(1);
          sum_d       = sum_q + rx_data;
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle stall inside a frame aborts it.
    if ((state_q != IDLE) && !accept && (tmo_q == TMO_LAST)) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = IDLE;
    end

    cpu_hold_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      debug_q     <= 1'b0;
      boot_addr_q <= '0;
      boot_data_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      wptr_q      <= '0;
      addr_lo_q   <= '0;
      len_lo_q    <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= 1'b1;
      debug_q     <= debug_d;
      boot_addr_q <= boot_addr_d;
      boot_data_q <= boot_data_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      wptr_q      <= wptr_d;
      addr_lo_q   <= addr_lo_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign debug     = debug_q;
  assign boot_addr = boot_addr_q;
  assign boot_data = boot_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a frame-level reference model tracks what each
// accepted byte or idle cycle must do; every cycle the outputs are compared
// against it, and per-test literal expectations pin the model.
module tb_boot_loader;

  localparam int ADDR_W = 13;
  localparam int MEMSZ  = 1 << ADDR_W;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              debug;
  logic [ADDR_W-1:0] boot_addr;
  logic [7:0]        boot_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  boot_loader #(
    .ADDR_W   (ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TMO),
    .TMO_W    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .debug    (debug),
    .boot_addr(boot_addr),
    .boot_data(boot_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: frame phase 0 idle, 1..4 header bytes, 5 payload, 6 checksum.
  int m_phase, m_alo, m_llo, m_wp, m_rem, m_sum, m_idle;
  int m_ready, m_debug, m_done, m_err, m_addr, m_data, m_code;

  function automatic void m_pulses_clear();
    m_ready = 1; m_debug = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void m_abort(int code);
    m_err = 1; m_code = code; m_phase = 0; m_idle = 0;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_alo = 0; m_llo = 0; m_wp = 0; m_rem = 0; m_sum = 0; m_idle = 0;
    m_ready = 0; m_debug = 0; m_done = 0; m_err = 0; m_addr = 0; m_data = 0; m_code = 0;
  endfunction

  function automatic void model_accept(int b);
    int len;
    m_pulses_clear();
    m_idle = 0;
    case (m_phase)
      0: if (b == 'hA5) begin m_phase = 1; m_sum = 0; end
      1: begin m_alo = b; m_phase = 2; end
      2: begin m_wp = (b * 256 + m_alo) % MEMSZ; m_phase = 3; end
      3: begin m_llo = b; m_phase = 4; end
      4: begin
        len = b * 256 + m_llo;
        if (len > MEMSZ) m_abort(2);
        else if (len == 0) m_phase = 6;
        else begin m_rem = len; m_phase = 5; end
      end
      5: begin
        m_debug = 1; m_addr = m_wp; m_data = b;
        m_wp = (m_wp + 1) % MEMSZ;
        m_sum = (m_sum + b) % 256;
        m_rem--;
        if (m_rem == 0) m_phase = 6;
      end
      default: begin
        if (b == m_sum) m_done = 1;
        else m_abort(1);
        m_phase = 0;
      end
    endcase
  endfunction

  function automatic void model_idle();
    m_pulses_clear();
    if (m_phase != 0) begin
      m_idle++;
      if (m_idle == TMO) m_abort(3);
    end
  endfunction

  // DUT observations collected for literal per-test checks.
  int d_wr_addr[$];
  int d_wr_data[$];
  int d_done, d_err, d_hold, d_code;
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rx_ready",  int'(rx_ready),  m_ready);
      check("cpu_hold",  int'(cpu_hold),  (m_phase != 0) ? 1 : 0);
      check("debug",     int'(debug),     m_debug);
      check("boot_addr", int'(boot_addr), m_addr);
      check("boot_data", int'(boot_data), m_data);
      check("done",      int'(done),      m_done);
      check("err",       int'(err),       m_err);
      check("err_code",  int'(err_code),  m_code);
      if (debug) begin
        d_wr_addr.push_back(int'(boot_addr));
        d_wr_data.push_back(int'(boot_data));
      end
      if (done) d_done++;
      if (err) d_err++;
      d_hold = int'(cpu_hold);
      d_code = int'(err_code);
    end
  end

  // One clock of stimulus; the model advances at the same posedge.
  task automatic step(input logic r, input logic v, input logic [7:0] b);
    logic rdy;
    @(negedge clk);
    rst = r; rx_valid = v; rx_data = b;
    rdy = rx_ready;
    @(posedge clk);
    if (r) model_reset();
    else if (v && rdy) model_accept(int'(b));
    else model_idle();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic clear_obs();
    d_wr_addr.delete(); d_wr_data.delete();
    d_done = 0; d_err = 0;
  endtask

  function automatic int wr_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    @(posedge clk);
    model_reset();
    cmp_en = 1;
    clear_obs();
    idle(2);

    // Normal frame.
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    idle(2);
    check("t1_nwr",   d_wr_addr.size(), 4);
    check("t1_addr0", wr_at(d_wr_addr, 0), 'h100);
    check("t1_data0", wr_at(d_wr_data, 0), 'h11);
    check("t1_addr3", wr_at(d_wr_addr, 3), 'h103);
    check("t1_data3", wr_at(d_wr_data, 3), 'h44);
    check("t1_done",  d_done, 1);
    check("t1_err",   d_err, 0);

    // Checksum error.
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB});
    idle(2);
    check("t2_nwr",  d_wr_addr.size(), 4);
    check("t2_err",  d_err, 1);
    check("t2_done", d_done, 0);
    check("t2_code", d_code, 1);

    // Garbage then a frame wrapping past the top of memory.
    clear_obs();
    send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hFF, 8'h1F, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03});
    idle(2);
    check("t3_nwr",   d_wr_addr.size(), 2);
    check("t3_addr0", wr_at(d_wr_addr, 0), 'h1FFF);
    check("t3_addr1", wr_at(d_wr_addr, 1), 'h0000);
    check("t3_data1", wr_at(d_wr_data, 1), 'h02);
    check("t3_done",  d_done, 1);

    // Zero length.
    clear_obs();
    send_list('{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00});
    idle(2);
    check("t4_nwr",  d_wr_addr.size(), 0);
    check("t4_done", d_done, 1);

    // Length one past the maximum.
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h00, 8'h01, 8'h20});
    idle(2);
    check("t5_nwr",  d_wr_addr.size(), 0);
    check("t5_err",  d_err, 1);
    check("t5_code", d_code, 2);
    check("t5_hold", d_hold, 0);

    // Maximum length: full memory, start 0x0005, payload i&0xFF sums to 0.
    clear_obs();
    send_list('{8'hA5, 8'h05, 8'h00, 8'h00, 8'h20});
    for (int i = 0; i < MEMSZ; i++) send(8'(i));
    send(8'h00);
    idle(2);
    check("t6_nwr",   d_wr_addr.size(), MEMSZ);
    check("t6_last",  wr_at(d_wr_addr, MEMSZ - 1), 'h0004);
    check("t6_done",  d_done, 1);

    // Timeout: one cycle short does not abort, the full stall does.
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h00});
    idle(TMO - 1);
    check("t7_early_err",  d_err, 0);
    check("t7_early_hold", d_hold, 1);
    idle(3);
    check("t7_err",  d_err, 1);
    check("t7_code", d_code, 3);
    check("t7_hold", d_hold, 0);

    // Recovery frame after timeout.
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'h7E, 8'h7E});
    idle(2);
    check("t8_nwr",  d_wr_addr.size(), 1);
    check("t8_addr", wr_at(d_wr_addr, 0), 'h200);
    check("t8_done", d_done, 1);

    // Reset after two payload bytes.
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h03, 8'h04, 8'h00, 8'h11, 8'h22});
    step(1'b1, 1'b0, 8'h00);
    idle(3);
    check("t9_nwr",  d_wr_addr.size(), 2);
    check("t9_done", d_done, 0);
    check("t9_err",  d_err, 0);
    check("t9_code", d_code, 0);
    check("t9_hold", d_hold, 0);
    clear_obs();
    send_list('{8'hA5, 8'h00, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    idle(2);
    check("t10_nwr",  d_wr_addr.size(), 4);
    check("t10_done", d_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
